// File: rtl/imm_ext_ctrl.sv
// -----------------------------------------------------------------------------
// imm_ext_ctrl
// Decode-stage immediate controller. Each instruction that Fetch hands over is
// classified by its opcode. The controller builds the extended immediate
// (sign, zero or LUI upper) and queues the result in a 2-entry skid buffer
// toward EX. The buffer decouples Fetch from an EX stage that can stall.
// A flush drops every buffered entry. A saturating counter records the cycles
// in which Fetch was held off.
//
// Ports
//   clock          rising-edge clock
//   i_rst_n        synchronous reset, active low (takes priority over flush)
//   i_flush        discard all buffered entries (branch mispredict)
//   i_valid_F      Fetch presents an instruction
//   i_instr_F      instruction word
//   o_ready_F      controller accepts an instruction this cycle (registered)
//   o_valid_D      head entry valid toward EX (registered)
//   i_ready_E      EX accepts the head entry this cycle
//   o_data_immD    extended immediate of the head entry
//   o_con_signext  head entry used sign extension
//   o_imm_kind     00 NONE, 01 SIGN, 10 ZERO, 11 UPPER
//   o_stall_cnt    saturating count of cycles with i_valid_F=1 and o_ready_F=0
// -----------------------------------------------------------------------------
module imm_ext_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_valid_F,
  input  logic [DATA_W-1:0] i_instr_F,
  output logic              o_ready_F,
  output logic              o_valid_D,
  input  logic              i_ready_E,
  output logic [DATA_W-1:0] o_data_immD,
  output logic              o_con_signext,
  output logic [1:0]        o_imm_kind,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_SIGN  = 2'b01;
  localparam logic [1:0] KIND_ZERO  = 2'b10;
  localparam logic [1:0] KIND_UPPER = 2'b11;

  // The state encodes how many entries are buffered.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              signext;
    logic [1:0]        kind;
  } entry_t;

  // Builds the buffered entry for one instruction word from its opcode.
  function automatic entry_t decode_entry(input logic [DATA_W-1:0] instr);
    entry_t           e;
    logic [IMM_W-1:0] imm;
    logic [5:0]       op;
    imm       = instr[IMM_W-1:0];
    op        = instr[DATA_W-1 -: 6];
    e.data    = '0;
    e.signext = 1'b0;
    e.kind    = KIND_NONE;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h04, 6'h05, 6'h23, 6'h2B: begin
        e.data    = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        e.signext = 1'b1;
        e.kind    = KIND_SIGN;
      end
      6'h0C, 6'h0D, 6'h0E: begin
        e.data    = {{(DATA_W-IMM_W){1'b0}}, imm};
        e.signext = 1'b0;
        e.kind    = KIND_ZERO;
      end
      6'h0F: begin
        e.data    = {imm, {(DATA_W-IMM_W){1'b0}}};
        e.signext = 1'b0;
        e.kind    = KIND_UPPER;
      end
      default: begin
        e.data    = '0;
        e.signext = 1'b0;
        e.kind    = KIND_NONE;
      end
    endcase
    return e;
  endfunction

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  entry_t           head_q,  head_d;
  entry_t           tail_q,  tail_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic             push_s;
  logic             pop_s;
  entry_t           new_entry_s;

  // Computes the next buffer state, the head/tail entries and the stall count.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    stall_d     = stall_q;
    push_s      = i_valid_F & ready_q;
    pop_s       = valid_q & i_ready_E;
    new_entry_s = decode_entry(i_instr_F);

    // Counting continues during a flush. The flush only affects the buffer.
    if (i_valid_F && !ready_q && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end

    if (i_flush) begin
      state_d = ST_EMPTY;
      valid_d = 1'b0;
      head_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            state_d = ST_ONE;
            valid_d = 1'b1;
            head_d  = new_entry_s;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_d = new_entry_s;
          end else if (push_s) begin
            state_d = ST_FULL;
            tail_d  = new_entry_s;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // ready_q is low here, so no push can land in the same cycle as the pop.
          if (pop_s) begin
            state_d = ST_ONE;
            head_d  = tail_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          valid_d = 1'b0;
          head_d  = '0;
        end
      endcase
    end

    ready_d = (state_d != ST_FULL);
  end

  // Holds the state and the registered outputs. Reset takes priority over everything else.
  always_ff @(posedge clock) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      stall_q <= stall_d;
    end
  end

  assign o_ready_F     = ready_q;
  assign o_valid_D     = valid_q;
  assign o_data_immD   = head_q.data;
  assign o_con_signext = head_q.signext;
  assign o_imm_kind    = head_q.kind;
  assign o_stall_cnt   = stall_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_ctrl
// Directed bench for imm_ext_ctrl. Inputs change 1 time unit after each rising
// edge. Outputs are checked at the same point, after the registers have settled.
// -----------------------------------------------------------------------------
module tb_imm_ext_ctrl;

  logic        clock;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_valid_F;
  logic [31:0] i_instr_F;
  logic        o_ready_F;
  logic        o_valid_D;
  logic        i_ready_E;
  logic [31:0] o_data_immD;
  logic        o_con_signext;
  logic [1:0]  o_imm_kind;
  logic [15:0] o_stall_cnt;

  int checks;
  int failures;

  imm_ext_ctrl #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) dut (
    .clock         (clock),
    .i_rst_n       (i_rst_n),
    .i_flush       (i_flush),
    .i_valid_F     (i_valid_F),
    .i_instr_F     (i_instr_F),
    .o_ready_F     (o_ready_F),
    .o_valid_D     (o_valid_D),
    .i_ready_E     (i_ready_E),
    .o_data_immD   (o_data_immD),
    .o_con_signext (o_con_signext),
    .o_imm_kind    (o_imm_kind),
    .o_stall_cnt   (o_stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    i_rst_n   = 1'b0;
    i_flush   = 1'b0;
    i_valid_F = 1'b0;
    i_instr_F = 32'h0000_0000;
    i_ready_E = 1'b1;

    // T1 reset held for two cycles
    step();
    step();
    chk("rst_valid",   {31'd0, o_valid_D},     32'd0);
    chk("rst_ready",   {31'd0, o_ready_F},     32'd1);
    chk("rst_stall",   {16'd0, o_stall_cnt},   32'd0);
    chk("rst_data",    o_data_immD,            32'h0000_0000);
    chk("rst_kind",    {30'd0, o_imm_kind},    32'd0);
    chk("rst_signext", {31'd0, o_con_signext}, 32'd0);
    i_rst_n = 1'b1;

    // T2 extension kinds
    i_ready_E = 1'b0;
    i_valid_F = 1'b1;
    i_instr_F = 32'h2008_FFFC;               // addi
    step();
    chk("addi_valid",   {31'd0, o_valid_D},     32'd1);
    chk("addi_data",    o_data_immD,            32'hFFFF_FFFC);
    chk("addi_kind",    {30'd0, o_imm_kind},    32'd1);
    chk("addi_signext", {31'd0, o_con_signext}, 32'd1);
    i_valid_F = 1'b0;
    i_ready_E = 1'b1;
    step();
    chk("addi_drained", {31'd0, o_valid_D},     32'd0);
    i_valid_F = 1'b1;
    i_instr_F = 32'h3508_FFFC;               // ori
    step();
    chk("ori_data",     o_data_immD,            32'h0000_FFFC);
    chk("ori_kind",     {30'd0, o_imm_kind},    32'd2);
    chk("ori_signext",  {31'd0, o_con_signext}, 32'd0);
    i_instr_F = 32'h3C08_1234;               // lui, pushed while ori pops
    step();
    chk("lui_valid",    {31'd0, o_valid_D},     32'd1);
    chk("lui_data",     o_data_immD,            32'h1234_0000);
    chk("lui_kind",     {30'd0, o_imm_kind},    32'd3);
    i_instr_F = 32'h8C41_8000;               // lw, negative offset
    step();
    chk("lw_data",      o_data_immD,            32'hFFFF_8000);
    chk("lw_kind",      {30'd0, o_imm_kind},    32'd1);
    i_instr_F = 32'h0041_FFFF;               // R-type: no immediate
    step();
    chk("rtype_data",   o_data_immD,            32'h0000_0000);
    chk("rtype_kind",   {30'd0, o_imm_kind},    32'd0);
    chk("rtype_valid",  {31'd0, o_valid_D},     32'd1);
    i_valid_F = 1'b0;
    step();
    chk("t2_empty",     {31'd0, o_valid_D},     32'd0);
    chk("t2_stall",     {16'd0, o_stall_cnt},   32'd0);

    // T3 backpressure: third push blocked, then drain in order
    i_ready_E = 1'b0;
    i_valid_F = 1'b1;
    i_instr_F = 32'h2001_0001;
    step();
    chk("bp_ready1",    {31'd0, o_ready_F},     32'd1);
    i_instr_F = 32'h2001_0002;
    step();
    chk("bp_ready2",    {31'd0, o_ready_F},     32'd0);
    chk("bp_head",      o_data_immD,            32'h0000_0001);
    i_instr_F = 32'h2001_0003;
    step();
    chk("bp_stall1",    {16'd0, o_stall_cnt},   32'd1);
    chk("bp_hold",      o_data_immD,            32'h0000_0001);
    step();
    chk("bp_stall2",    {16'd0, o_stall_cnt},   32'd2);
    i_ready_E = 1'b1;
    step();
    chk("drain_b",      o_data_immD,            32'h0000_0002);
    chk("drain_stall",  {16'd0, o_stall_cnt},   32'd3);
    chk("drain_ready",  {31'd0, o_ready_F},     32'd1);
    step();
    chk("drain_c",      o_data_immD,            32'h0000_0003);
    chk("drain_c_vld",  {31'd0, o_valid_D},     32'd1);
    i_valid_F = 1'b0;
    step();
    chk("drain_empty",  {31'd0, o_valid_D},     32'd0);

    // T4 throughput: eight back-to-back ori, one output per cycle
    i_valid_F = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_instr_F = {6'h0D, 10'd0, 16'(i * 16'h0111)};
      step();
      chk($sformatf("tp_valid%0d", i), {31'd0, o_valid_D}, 32'd1);
      chk($sformatf("tp_data%0d", i),  o_data_immD,        {16'd0, 16'(i * 16'h0111)});
    end
    i_valid_F = 1'b0;
    step();
    chk("tp_end",       {31'd0, o_valid_D},     32'd0);

    // T5 flush while full with a push in the same cycle
    i_ready_E = 1'b0;
    i_valid_F = 1'b1;
    i_instr_F = 32'h3400_0AAA;
    step();
    i_instr_F = 32'h3C00_5555;
    step();
    chk("fl_full",      {31'd0, o_ready_F},     32'd0);
    i_instr_F = 32'h2000_7777;
    i_flush   = 1'b1;
    step();
    chk("fl_valid",     {31'd0, o_valid_D},     32'd0);
    chk("fl_ready",     {31'd0, o_ready_F},     32'd1);
    chk("fl_stall",     {16'd0, o_stall_cnt},   32'd4);
    i_flush   = 1'b0;
    i_valid_F = 1'b0;
    i_ready_E = 1'b1;
    step();
    chk("fl_no_emit",   {31'd0, o_valid_D},     32'd0);

    // T6 saturation: hold full with Fetch pushing for 70000 cycles
    i_ready_E = 1'b0;
    i_valid_F = 1'b1;
    i_instr_F = 32'h2000_0042;
    step();
    i_instr_F = 32'h2000_0043;
    step();
    i_instr_F = 32'h2000_0044;
    repeat (70000) @(posedge clock);
    #1;
    chk("sat_stall",    {16'd0, o_stall_cnt},   32'h0000_FFFF);
    chk("sat_head",     o_data_immD,            32'h0000_0042);
    i_rst_n = 1'b0;
    i_flush = 1'b1;
    step();
    chk("mrst_stall",   {16'd0, o_stall_cnt},   32'd0);
    chk("mrst_valid",   {31'd0, o_valid_D},     32'd0);
    chk("mrst_ready",   {31'd0, o_ready_F},     32'd1);
    chk("mrst_data",    o_data_immD,            32'h0000_0000);
    i_rst_n   = 1'b1;
    i_flush   = 1'b0;
    i_valid_F = 1'b0;
    i_ready_E = 1'b1;
    step();
    chk("post_valid",   {31'd0, o_valid_D},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
